// File: rtl/wbu_if.sv
// Write-back stage bus: memory-stage inputs,
// decode read ports, commit/halt status.
interface wbu_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            instr_valid;
  logic            mmu_valid;
  logic            mmu_wb_en;
  logic [AW-1:0]   mmu_index_rd;
  logic [XLEN-1:0] mmu_wb_data;
  logic            mmu_ebreak_en;
  logic [XLEN-1:0] mmu_pc;
  logic [31:0]     mmu_instr;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [31:0]     commit_instr;
  logic [XLEN-1:0] retire_cnt;
  logic [XLEN-1:0] cycle_cnt;
  logic            halt;
  logic [XLEN-1:0] exit_code;

  modport master (
    output instr_valid, mmu_valid, mmu_wb_en,
    output mmu_index_rd, mmu_wb_data,
    output mmu_ebreak_en, mmu_pc, mmu_instr,
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data,
    input  commit_valid, commit_pc, commit_instr,
    input  retire_cnt, cycle_cnt, halt, exit_code
  );

  modport slave (
    input  instr_valid, mmu_valid, mmu_wb_en,
    input  mmu_index_rd, mmu_wb_data,
    input  mmu_ebreak_en, mmu_pc, mmu_instr,
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data,
    output commit_valid, commit_pc, commit_instr,
    output retire_cnt, cycle_cnt, halt, exit_code
  );
endinterface

// File: rtl/wbu.sv
// Write-back stage: integer register file,
// bypassed reads, commit info, ebreak halt.
module wbu #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input logic   clk,
  input logic   rstn,
  wbu_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] A0 = AW'(10);

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            run;
  logic            fire;
  logic            wen;
  logic [XLEN-1:0] a0_byp;
  logic [XLEN-1:0] regs [NREG];

  assign run  = (state == RUN);
  assign fire = bus.instr_valid & bus.mmu_valid & run;
  assign wen  = fire & bus.mmu_wb_en
              & (bus.mmu_index_rd != '0);
  assign bus.halt = (state == HALT);

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= RUN;
    else       state <= state_nxt;
  end

  // Next state: ebreak retirement halts for good
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:  if (fire && bus.mmu_ebreak_en)
              state_nxt = HALT;
      HALT: state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  // Register file; entry 0 never written
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wen) begin
      regs[bus.mmu_index_rd] <= bus.mmu_wb_data;
    end
  end

  // Read port 1: x0, then write-first bypass
  always_comb begin
    bus.rs1_data = '0;
    if (bus.rs1_addr == '0)
      bus.rs1_data = '0;
    else if (wen && bus.rs1_addr == bus.mmu_index_rd)
      bus.rs1_data = bus.mmu_wb_data;
    else
      bus.rs1_data = regs[bus.rs1_addr];
  end

  // Read port 2: same priority as port 1
  always_comb begin
    bus.rs2_data = '0;
    if (bus.rs2_addr == '0)
      bus.rs2_data = '0;
    else if (wen && bus.rs2_addr == bus.mmu_index_rd)
      bus.rs2_data = bus.mmu_wb_data;
    else
      bus.rs2_data = regs[bus.rs2_addr];
  end

  // a0 as seen this cycle, for the exit code
  always_comb begin
    a0_byp = regs[A0];
    if (wen && bus.mmu_index_rd == A0)
      a0_byp = bus.mmu_wb_data;
  end

  // Commit record of the last retirement
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.commit_valid <= 1'b0;
      bus.commit_pc    <= '0;
      bus.commit_instr <= '0;
    end else begin
      bus.commit_valid <= fire;
      if (fire) begin
        bus.commit_pc    <= bus.mmu_pc;
        bus.commit_instr <= bus.mmu_instr;
      end
    end
  end

  // Retire and cycle counters, frozen in HALT
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.retire_cnt <= '0;
      bus.cycle_cnt  <= '0;
    end else begin
      if (fire) bus.retire_cnt <= bus.retire_cnt + 1'b1;
      if (run)  bus.cycle_cnt  <= bus.cycle_cnt + 1'b1;
    end
  end

  // Exit code captured on the halting edge
  always_ff @(posedge clk) begin
    if (!rstn)
      bus.exit_code <= '0;
    else if (fire && bus.mmu_ebreak_en)
      bus.exit_code <= a0_byp;
  end
endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: bypass, x0, stall,
// bubble, ebreak halt, reset from HALT.
module tb_wbu;
  logic clk;
  logic rstn;
  int   checks;
  int   fails;

  wbu_if #(.XLEN(64), .AW(5)) bus ();

  wbu dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic        iv,
    input logic        mv,
    input logic        we,
    input logic [4:0]  rd,
    input logic [63:0] d,
    input logic        eb,
    input logic [63:0] pc,
    input logic [31:0] ins
  );
    bus.instr_valid   = iv;
    bus.mmu_valid     = mv;
    bus.mmu_wb_en     = we;
    bus.mmu_index_rd  = rd;
    bus.mmu_wb_data   = d;
    bus.mmu_ebreak_en = eb;
    bus.mmu_pc        = pc;
    bus.mmu_instr     = ins;
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd10;
    do_reset();
    checks += 6;
    if (bus.halt !== 1'b0) begin
      fails++; $display("FAIL rst_halt got %h exp 0", bus.halt);
    end
    if (bus.commit_valid !== 1'b0) begin
      fails++; $display("FAIL rst_cv got %h exp 0", bus.commit_valid);
    end
    if (bus.retire_cnt !== 64'd0) begin
      fails++; $display("FAIL rst_ret got %h exp 0", bus.retire_cnt);
    end
    if (bus.cycle_cnt !== 64'd0) begin
      fails++; $display("FAIL rst_cyc got %h exp 0", bus.cycle_cnt);
    end
    if (bus.exit_code !== 64'd0) begin
      fails++; $display("FAIL rst_exit got %h exp 0", bus.exit_code);
    end
    if (bus.rs1_data !== 64'd0) begin
      fails++; $display("FAIL rst_rs1 got %h exp 0", bus.rs1_data);
    end
  endtask

  task automatic test_bypass();
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd5;
    drive(1, 1, 1, 5, 64'h1234, 0, 64'h8000_0000, 32'h0010_0093);
    checks += 2;
    if (bus.rs1_data !== 64'h1234) begin
      fails++; $display("FAIL byp_rs1 got %h exp 1234", bus.rs1_data);
    end
    if (bus.rs2_data !== 64'h1234) begin
      fails++; $display("FAIL byp_rs2 got %h exp 1234", bus.rs2_data);
    end
    tick();
    drive(0, 1, 1, 5, 64'h9999, 0, 64'h4, 32'h0);
    checks += 5;
    if (bus.rs1_data !== 64'h1234) begin
      fails++; $display("FAIL stored_rs1 got %h exp 1234", bus.rs1_data);
    end
    if (bus.commit_valid !== 1'b1) begin
      fails++; $display("FAIL byp_cv got %h exp 1", bus.commit_valid);
    end
    if (bus.commit_pc !== 64'h8000_0000) begin
      fails++; $display("FAIL byp_pc got %h exp 80000000", bus.commit_pc);
    end
    if (bus.commit_instr !== 32'h0010_0093) begin
      fails++; $display("FAIL byp_ins got %h exp 00100093", bus.commit_instr);
    end
    if (bus.retire_cnt !== 64'd1) begin
      fails++; $display("FAIL byp_ret got %h exp 1", bus.retire_cnt);
    end
    tick();
    checks += 3;
    if (bus.commit_valid !== 1'b0) begin
      fails++; $display("FAIL byp_cv_drop got %h exp 0", bus.commit_valid);
    end
    if (bus.commit_pc !== 64'h8000_0000) begin
      fails++; $display("FAIL byp_pc_hold got %h exp 80000000", bus.commit_pc);
    end
    if (bus.rs1_data !== 64'h1234) begin
      fails++; $display("FAIL stall_nowr got %h exp 1234", bus.rs1_data);
    end
  endtask

  task automatic test_x0();
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    drive(1, 1, 1, 0, '1, 0, 64'h10, 32'h13);
    checks += 1;
    if (bus.rs1_data !== 64'd0) begin
      fails++; $display("FAIL x0_same got %h exp 0", bus.rs1_data);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks += 2;
    if (bus.rs2_data !== 64'd0) begin
      fails++; $display("FAIL x0_later got %h exp 0", bus.rs2_data);
    end
    if (bus.retire_cnt !== 64'd2) begin
      fails++; $display("FAIL x0_ret got %h exp 2", bus.retire_cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.rs1_addr = 5'd7;
    drive(0, 1, 1, 7, 64'h77, 0, 64'h20, 32'h33);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 2;
      if (bus.rs1_data !== 64'd0) begin
        fails++; $display("FAIL stall_x7 got %h exp 0", bus.rs1_data);
      end
      if (bus.commit_valid !== 1'b0) begin
        fails++; $display("FAIL stall_cv got %h exp 0", bus.commit_valid);
      end
    end
    drive(1, 1, 1, 7, 64'h77, 0, 64'h20, 32'h33);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks += 4;
    if (bus.rs1_data !== 64'h77) begin
      fails++; $display("FAIL stall_wr got %h exp 77", bus.rs1_data);
    end
    if (bus.commit_valid !== 1'b1) begin
      fails++; $display("FAIL stall_cv1 got %h exp 1", bus.commit_valid);
    end
    if (bus.cycle_cnt !== 64'd4) begin
      fails++; $display("FAIL stall_cyc got %h exp 4", bus.cycle_cnt);
    end
    if (bus.retire_cnt !== 64'd1) begin
      fails++; $display("FAIL stall_ret got %h exp 1", bus.retire_cnt);
    end
  endtask

  task automatic test_bubble();
    bus.rs1_addr = 5'd3;
    drive(1, 0, 1, 3, 64'hdead, 0, 64'h30, 32'h13);
    checks += 1;
    if (bus.rs1_data !== 64'd0) begin
      fails++; $display("FAIL bub_byp got %h exp 0", bus.rs1_data);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks += 3;
    if (bus.rs1_data !== 64'd0) begin
      fails++; $display("FAIL bub_x3 got %h exp 0", bus.rs1_data);
    end
    if (bus.commit_valid !== 1'b0) begin
      fails++; $display("FAIL bub_cv got %h exp 0", bus.commit_valid);
    end
    if (bus.retire_cnt !== 64'd1) begin
      fails++; $display("FAIL bub_ret got %h exp 1", bus.retire_cnt);
    end
  endtask

  task automatic test_ebreak();
    drive(1, 1, 1, 5, 64'd7, 0, 64'h40, 32'h13);
    tick();
    drive(1, 1, 1, 10, 64'd42, 0, 64'h44, 32'h13);
    tick();
    drive(1, 1, 0, 0, 0, 1, 64'h48, 32'h0010_0073);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks += 6;
    if (bus.halt !== 1'b1) begin
      fails++; $display("FAIL eb_halt got %h exp 1", bus.halt);
    end
    if (bus.exit_code !== 64'd42) begin
      fails++; $display("FAIL eb_exit got %h exp 2a", bus.exit_code);
    end
    if (bus.retire_cnt !== 64'd4) begin
      fails++; $display("FAIL eb_ret got %h exp 4", bus.retire_cnt);
    end
    if (bus.cycle_cnt !== 64'd8) begin
      fails++; $display("FAIL eb_cyc got %h exp 8", bus.cycle_cnt);
    end
    if (bus.commit_pc !== 64'h48) begin
      fails++; $display("FAIL eb_pc got %h exp 48", bus.commit_pc);
    end
    if (bus.commit_valid !== 1'b1) begin
      fails++; $display("FAIL eb_cv got %h exp 1", bus.commit_valid);
    end
    bus.rs1_addr = 5'd1;
    bus.rs2_addr = 5'd5;
    drive(1, 1, 1, 1, 64'h99, 0, 64'h4c, 32'h13);
    checks += 1;
    if (bus.rs1_data !== 64'd0) begin
      fails++; $display("FAIL halt_byp got %h exp 0", bus.rs1_data);
    end
    tick();
    tick();
    checks += 6;
    if (bus.rs1_data !== 64'd0) begin
      fails++; $display("FAIL halt_x1 got %h exp 0", bus.rs1_data);
    end
    if (bus.rs2_data !== 64'd7) begin
      fails++; $display("FAIL halt_x5 got %h exp 7", bus.rs2_data);
    end
    if (bus.retire_cnt !== 64'd4) begin
      fails++; $display("FAIL halt_ret got %h exp 4", bus.retire_cnt);
    end
    if (bus.cycle_cnt !== 64'd8) begin
      fails++; $display("FAIL halt_cyc got %h exp 8", bus.cycle_cnt);
    end
    if (bus.commit_valid !== 1'b0) begin
      fails++; $display("FAIL halt_cv got %h exp 0", bus.commit_valid);
    end
    if (bus.halt !== 1'b1) begin
      fails++; $display("FAIL halt_stay got %h exp 1", bus.halt);
    end
  endtask

  task automatic test_halt_reset();
    bus.rs2_addr = 5'd5;
    do_reset();
    checks += 6;
    if (bus.halt !== 1'b0) begin
      fails++; $display("FAIL hr_halt got %h exp 0", bus.halt);
    end
    if (bus.rs2_data !== 64'd0) begin
      fails++; $display("FAIL hr_x5 got %h exp 0", bus.rs2_data);
    end
    if (bus.retire_cnt !== 64'd0) begin
      fails++; $display("FAIL hr_ret got %h exp 0", bus.retire_cnt);
    end
    if (bus.cycle_cnt !== 64'd0) begin
      fails++; $display("FAIL hr_cyc got %h exp 0", bus.cycle_cnt);
    end
    if (bus.commit_valid !== 1'b0) begin
      fails++; $display("FAIL hr_cv got %h exp 0", bus.commit_valid);
    end
    if (bus.exit_code !== 64'd0) begin
      fails++; $display("FAIL hr_exit got %h exp 0", bus.exit_code);
    end
  endtask

  task automatic test_back_to_back();
    bus.rs1_addr = 5'd1;
    bus.rs2_addr = 5'd2;
    drive(1, 1, 1, 1, 64'h11, 0, 64'h100, 32'ha1);
    tick();
    drive(1, 1, 1, 2, 64'h22, 0, 64'h104, 32'ha2);
    checks += 3;
    if (bus.rs1_data !== 64'h11) begin
      fails++; $display("FAIL b2b_x1 got %h exp 11", bus.rs1_data);
    end
    if (bus.rs2_data !== 64'h22) begin
      fails++; $display("FAIL b2b_x2 got %h exp 22", bus.rs2_data);
    end
    if (bus.commit_pc !== 64'h100) begin
      fails++; $display("FAIL b2b_pc1 got %h exp 100", bus.commit_pc);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks += 4;
    if (bus.commit_pc !== 64'h104) begin
      fails++; $display("FAIL b2b_pc2 got %h exp 104", bus.commit_pc);
    end
    if (bus.commit_instr !== 32'ha2) begin
      fails++; $display("FAIL b2b_ins got %h exp a2", bus.commit_instr);
    end
    if (bus.commit_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_cv got %h exp 1", bus.commit_valid);
    end
    if (bus.retire_cnt !== 64'd2) begin
      fails++; $display("FAIL b2b_ret got %h exp 2", bus.retire_cnt);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rstn   = 1'b0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_bypass();
    test_x0();
    test_stall();
    test_bubble();
    test_ebreak();
    test_halt_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
